// File: rtl/instruction_queue.sv
// Show-ahead circular instruction FIFO between fetch and rename/dispatch.
// Each entry holds the fetched instruction word and its next-PC (pc + 4).
module instruction_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned PTR_BITS = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                enq_valid,
    input  logic [31:0]         enq_inst,
    input  logic [31:0]         enq_pc,
    output logic                full,
    input  logic                dequeue,
    output logic [31:0]         inst,
    output logic [31:0]         prog,
    output logic                is_iqueue_empty,
    output logic [PTR_BITS:0]   count
);

    localparam logic [PTR_BITS:0] PTR_ONE = {{PTR_BITS{1'b0}}, 1'b1};

    logic [63:0]         mem [DEPTH];
    logic [PTR_BITS:0]   head;
    logic [PTR_BITS:0]   tail;
    logic [PTR_BITS-1:0] head_idx;
    logic [PTR_BITS-1:0] tail_idx;
    logic                enq_ok;
    logic                deq_ok;

    assign head_idx = head[PTR_BITS-1:0];
    assign tail_idx = tail[PTR_BITS-1:0];

    // Status comes from registered pointers only; wrap bit separates full from empty.
    assign is_iqueue_empty = (head == tail);
    assign full            = (head_idx == tail_idx) && (head[PTR_BITS] != tail[PTR_BITS]);
    assign count           = tail - head;

    assign enq_ok = enq_valid && !full && !flush;
    assign deq_ok = dequeue && !is_iqueue_empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_ok) tail <= tail + PTR_ONE;
            if (deq_ok) head <= head + PTR_ONE;
        end
    end

    // Storage is not reset; contents are only observable between head and tail.
    always_ff @(posedge clk) begin
        if (rst_n && enq_ok) begin
            mem[tail_idx] <= {enq_inst, enq_pc + 32'd4};
        end
    end

    always_comb begin
        inst = '0;
        prog = '0;
        if (!is_iqueue_empty) begin
            inst = mem[head_idx][63:32];
            prog = mem[head_idx][31:0];
        end
    end

endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (DEPTH = 16).
module tb_instruction_queue;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned PTR_BITS = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              enq_valid;
    logic [31:0]       enq_inst;
    logic [31:0]       enq_pc;
    logic              full;
    logic              dequeue;
    logic [31:0]       inst;
    logic [31:0]       prog;
    logic              is_iqueue_empty;
    logic [PTR_BITS:0] count;

    int n_checks;
    int n_fail;

    instruction_queue #(.DEPTH(DEPTH), .PTR_BITS(PTR_BITS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .enq_valid       (enq_valid),
        .enq_inst        (enq_inst),
        .enq_pc          (enq_pc),
        .full            (full),
        .dequeue         (dequeue),
        .inst            (inst),
        .prog            (prog),
        .is_iqueue_empty (is_iqueue_empty),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, 32'(is_iqueue_empty), 32'd1);
        chk({tag, "_full"},  32'(full),            32'd0);
        chk({tag, "_count"}, 32'(count),           32'd0);
        chk({tag, "_inst"},  inst,                 32'd0);
        chk({tag, "_prog"},  prog,                 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        enq_valid = 1'b0;
        enq_inst  = '0;
        enq_pc    = '0;
        dequeue   = 1'b0;

        // Reset held for two edges.
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Basic enqueue; nothing visible before the edge.
        enq_valid = 1'b1;
        enq_inst  = 32'h0050_0093;
        enq_pc    = 32'h0000_1000;
        #1;
        chk("no_bypass_inst", inst, 32'd0);
        step();
        enq_valid = 1'b0;
        chk("basic_inst",  inst, 32'h0050_0093);
        chk("basic_prog",  prog, 32'h0000_1004);
        chk("basic_count", 32'(count), 32'd1);
        chk("basic_empty", 32'(is_iqueue_empty), 32'd0);
        dequeue = 1'b1;
        step();
        dequeue = 1'b0;
        chk("basic_deq_empty", 32'(is_iqueue_empty), 32'd1);
        chk("basic_deq_inst",  inst, 32'd0);
        chk("basic_deq_prog",  prog, 32'd0);

        // Fill with 17 back-to-back enqueues; the 17th is dropped.
        enq_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            enq_inst = 32'h1000_0000 + 32'(i);
            enq_pc   = 32'(i) * 32'd4;
            step();
            chk("fill_full", 32'(full), (i >= 15) ? 32'd1 : 32'd0);
        end
        enq_valid = 1'b0;
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_head_inst", inst, 32'h1000_0000);
        chk("fill_head_prog", prog, 32'h0000_0004);

        // Enq+deq at full: only the dequeue is accepted.
        enq_valid = 1'b1;
        enq_inst  = 32'hDEAD_BEEF;
        enq_pc    = 32'h0000_0999;
        dequeue   = 1'b1;
        step();
        enq_valid = 1'b0;
        chk("full_both_count", 32'(count), 32'd15);
        chk("full_both_full",  32'(full),  32'd0);

        // Drain the remaining 15; order continues at pc 0x8 and the dropped entry never appears.
        for (int i = 1; i < 16; i++) begin
            chk("drain_inst", inst, 32'h1000_0000 + 32'(i));
            chk("drain_prog", prog, 32'(i) * 32'd4 + 32'd4);
            step();
        end
        dequeue = 1'b0;
        chk("drain_empty", 32'(is_iqueue_empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // Enq+deq while empty: only the enqueue is accepted.
        enq_valid = 1'b1;
        enq_inst  = 32'h0000_000A;
        enq_pc    = 32'h0000_0100;
        dequeue   = 1'b1;
        step();
        enq_valid = 1'b0;
        dequeue   = 1'b0;
        chk("empty_both_count", 32'(count), 32'd1);
        chk("empty_both_prog",  prog, 32'h0000_0104);
        dequeue = 1'b1;
        step();
        dequeue = 1'b0;
        chk("empty_both_drain", 32'(is_iqueue_empty), 32'd1);

        // Wrap-around with steady occupancy of 3.
        enq_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            enq_inst = 32'(k);
            enq_pc   = 32'h0000_3000 + 32'(k) * 32'd4;
            step();
        end
        chk("wrap_prefill_count", 32'(count), 32'd3);
        dequeue = 1'b1;
        for (int j = 0; j < 40; j++) begin
            enq_inst = 32'(j + 3);
            enq_pc   = 32'h0000_3000 + 32'(j + 3) * 32'd4;
            chk("wrap_inst", inst, 32'(j));
            chk("wrap_prog", prog, 32'h0000_3000 + 32'(j) * 32'd4 + 32'd4);
            step();
            chk("wrap_count", 32'(count), 32'd3);
        end
        enq_valid = 1'b0;
        for (int j = 40; j < 43; j++) begin
            chk("wrap_tail_inst", inst, 32'(j));
            step();
        end
        dequeue = 1'b0;
        chk("wrap_end_empty", 32'(is_iqueue_empty), 32'd1);

        // Flush with 5 entries, together with enqueue and dequeue.
        enq_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            enq_inst = 32'h5000_0000 + 32'(k);
            enq_pc   = 32'h0000_4000 + 32'(k) * 32'd4;
            step();
        end
        chk("flush_pre_count", 32'(count), 32'd5);
        flush   = 1'b1;
        dequeue = 1'b1;
        step();
        flush     = 1'b0;
        dequeue   = 1'b0;
        enq_valid = 1'b0;
        chk_reset_outputs("flush");
        enq_valid = 1'b1;
        enq_inst  = 32'h0000_0013;
        enq_pc    = 32'h0000_2000;
        step();
        chk("flush_after_prog", prog, 32'h0000_2004);
        chk("flush_after_inst", inst, 32'h0000_0013);

        // PC wrap: next-PC of 0xFFFFFFFC is 0.
        enq_inst = 32'h7777_0001;
        enq_pc   = 32'hFFFF_FFFC;
        step();
        enq_valid = 1'b0;
        chk("pcwrap_count", 32'(count), 32'd2);
        dequeue = 1'b1;
        step();
        dequeue = 1'b0;
        chk("pcwrap_inst", inst, 32'h7777_0001);
        chk("pcwrap_prog", prog, 32'h0000_0000);

        // Grow to 7 entries, then a one-edge reset mid-run.
        enq_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            enq_inst = 32'h6000_0000 + 32'(k);
            enq_pc   = 32'h0000_6000 + 32'(k) * 32'd4;
            step();
        end
        chk("midrst_pre_count", 32'(count), 32'd7);
        rst_n   = 1'b0;
        dequeue = 1'b1;
        step();
        rst_n     = 1'b1;
        dequeue   = 1'b0;
        enq_valid = 1'b0;
        chk_reset_outputs("midrst");
        step();
        chk("midrst_hold_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Circular FIFO between fetch and `rename_dispatch`. It buffers fetched instructions with their next-PC and presents the oldest entry show-ahead, so rename can sample `inst`/`prog` and pop with `dequeue` in the same cycle. It provides `is_iqueue_empty` and `full` status, and a flush that discards all entries on a redirect.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, at least 2.
- `PTR_BITS`, $clog2(DEPTH), index width; pointers carry one extra wrap bit.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low; sampled on posedge `clk`.
- `flush`  in  1  discard all entries (branch redirect).
- `enq_valid`  in  1  fetch presents an instruction this cycle.
- `enq_inst`  in  32  fetched instruction word.
- `enq_pc`  in  32  PC of the fetched instruction.
- `full`  out  1  queue holds `DEPTH` entries; fetch must not enqueue.
- `dequeue`  in  1  rename consumes the head entry this cycle.
- `inst`  out  32  head instruction; 0 when empty.
- `prog`  out  32  head `enq_pc + 4`; 0 when empty.
- `is_iqueue_empty`  out  1  queue holds 0 entries.
- `count`  out  PTR_BITS+1  current occupancy, 0..DEPTH.

## Operation
- Storage: `DEPTH` entries of {inst[31:0], prog[31:0]}, with `head` and `tail` pointers of PTR_BITS+1 bits. Index = low PTR_BITS. Empty when head == tail. Full when indices are equal and wrap bits differ.
- Enqueue accepted when `enq_valid && !full && !flush`. It writes {`enq_inst`, `enq_pc + 32'd4`} at tail and increments tail. `prog` addition is modulo 2^32.
- Enqueue while `full` is dropped silently: no write, no pointer change. Fetch is responsible for stalling.
- Dequeue accepted when `dequeue && !is_iqueue_empty && !flush`. It increments head. Dequeue while empty is ignored.
- Simultaneous accepted enqueue and dequeue: both pointers advance and `count` is unchanged.
- `full` is evaluated on current state. A same-cycle dequeue does not make room for an enqueue at full.
- Flush: on the next posedge, head = tail = 0 and `count` = 0. Any same-cycle enqueue or dequeue is discarded. Memory contents are don't-care.
- Pointer wrap: incrementing from index DEPTH-1 goes to index 0 and toggles the wrap bit.
- Head outputs are combinational reads of entry[head index], gated to 0 when empty. Memory has no reset.
- `count` = tail − head, modulo 2^(PTR_BITS+1).

## Timing
- Reset: when `rst_n` = 0 at posedge, head = tail = 0. The same cycle's enq/deq are ignored. Outputs after reset: `is_iqueue_empty`=1, `full`=0, `count`=0, `inst`=0, `prog`=0. Reset mid-operation has the same effect as flush.
- Enqueue-to-visible latency is 1 cycle. An entry written at edge N appears on `inst`/`prog` after edge N (cycle N+1) if the queue was empty. There is no same-cycle bypass.
- Dequeue takes effect at the edge. Head outputs show the next entry in the following cycle.
- `full`, `is_iqueue_empty` and `count` are derived from registered pointers only. There is no combinational path from `enq_valid`, `dequeue` or `flush` to any output.
- Priority: `rst_n` low > `flush` > enqueue/dequeue.
- Throughput: one enqueue and one dequeue per cycle, sustained.

## Test plan
- Reset/basic: hold `rst_n`=0 for 2 cycles, then enqueue inst 0x00500093 at pc 0x1000 -> the next cycle shows `inst`=0x00500093, `prog`=0x1004, `count`=1, `is_iqueue_empty`=0. Pulse `dequeue` -> the cycle after, `is_iqueue_empty`=1 and `inst`=0.
- Fill/overflow (DEPTH=16): enqueue 17 instructions at pc 0x0,0x4,…,0x40 back-to-back -> `full`=1 after 16, `count`=16, and the 17th is dropped. Drain 16 -> `prog` sequence 0x4..0x40, then empty.
- Wrap-around: interleave enq/deq for 40 cycles, keeping occupancy 3 -> FIFO order is preserved across index 15→0, and `count` stays 3 throughout.
- Simultaneous at boundaries: at `count`=16 assert enq+deq -> only the dequeue is accepted and `count`=15. At `count`=0 assert enq+deq -> only the enqueue is accepted and `count`=1.
- Flush: with 5 entries, assert `flush` together with `enq_valid` and `dequeue` -> next cycle `count`=0, `is_iqueue_empty`=1, `inst`=0. Enqueue pc 0x2000 -> `prog`=0x2004.
- PC wrap and mid-run reset: enqueue pc 0xFFFFFFFC -> `prog`=0x00000000. With 7 entries, drive `rst_n`=0 for one edge -> all outputs return to their reset values.
